// File: rtl/gpc_1_1.sv
// gpc_1_1: registered 1:1 generalized parallel counter.
// Leaf cell of the GPC tree; each lane's count is its single input bit.
module gpc_1_1 #(
    parameter int LANES   = 1,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [LANES-1:0] src0,
    output logic             out_valid,
    output logic [LANES-1:0] dst
);

    if (LANES < 1 || LANES > 64) begin : g_bad_lanes
        $error("gpc_1_1: LANES must be in 1..64");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("gpc_1_1: LATENCY must be in 1..4");
    end

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LANES-1:0]   dat_q [LATENCY];
    logic [LANES-1:0]   dat_d [LATENCY];

    // Next state: valid shifts every cycle, data loads only behind a valid.
    always_comb begin
        vld_d[0] = in_valid;
        dat_d[0] = in_valid ? src0 : dat_q[0];
        for (int k = 1; k < LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
        end
    end

    // Pipeline registers; reset flushes every stage and beats in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < LATENCY; k++) begin
                dat_q[k] <= dat_d[k];
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign dst       = dat_q[LATENCY-1];

endmodule

// File: tb/tb_gpc_1_1.sv
// tb_gpc_1_1: checks four gpc_1_1 configurations against a history model.
// Latencies 1..4 share stimulus; directed tables plus random traffic.
module tb_gpc_1_1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] src;

    logic       ov1, ov2, ov3, ov4;
    logic [0:0] d1;
    logic [7:0] d2, d3, d4;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int n        = 0;

    logic       lr [4096];
    logic       lv [4096];
    logic [7:0] ls [4096];

    always #5 clk = ~clk;

    gpc_1_1 #(.LANES(1), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .src0(src[0]),
        .out_valid(ov1), .dst(d1));
    gpc_1_1 #(.LANES(8), .LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .src0(src),
        .out_valid(ov2), .dst(d2));
    gpc_1_1 #(.LANES(8), .LATENCY(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .src0(src),
        .out_valid(ov3), .dst(d3));
    gpc_1_1 #(.LANES(8), .LATENCY(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .src0(src),
        .out_valid(ov4), .dst(d4));

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at edge %0d: got %h, want %h",
                      name, n, act, exp);
    endtask

    // Expected output of a latency-L counter after the edges logged so far.
    // The sample at edge n-L is on the output if valid and no reset has
    // hit it since; dst is the newest surviving valid sample, else 0.
    task automatic model(input int L, output logic ov, output logic [7:0] d);
        int  s;
        bit  killed;
        s      = n - L;
        ov     = 1'b0;
        d      = 8'h00;
        killed = 1'b0;
        if (s < 0) return;
        for (int e = s + 1; e < n; e++) if (lr[e]) killed = 1'b1;
        if (killed) return;
        ov = lv[s] && !lr[s];
        for (int m = s; m >= 0; m--) begin
            if (lr[m]) return;
            if (lv[m]) begin
                d = ls[m];
                return;
            end
        end
    endtask

    task automatic model_check();
        logic       eov;
        logic [7:0] ed;
        model(1, eov, ed);
        check("u1.out_valid", {7'd0, ov1}, {7'd0, eov});
        check("u1.dst", {7'd0, d1}, {7'd0, ed[0]});
        model(2, eov, ed);
        check("u2.out_valid", {7'd0, ov2}, {7'd0, eov});
        check("u2.dst", d2, ed);
        model(3, eov, ed);
        check("u3.out_valid", {7'd0, ov3}, {7'd0, eov});
        check("u3.dst", d3, ed);
        model(4, eov, ed);
        check("u4.out_valid", {7'd0, ov4}, {7'd0, eov});
        check("u4.dst", d4, ed);
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] s);
        rst      = r;
        in_valid = v;
        src      = s;
        lr[n]    = r;
        lv[n]    = v;
        ls[n]    = s;
        @(posedge clk);
        n++;
        #1;
        model_check();
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] s;
        logic       eov;
        logic [7:0] ed;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [19:0] seq;

        tbl[0] = '{1'b1, 1'b1, 8'hFF, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 1'b1, 8'hFF, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'h00};
        tbl[3] = '{1'b0, 1'b1, 8'h3C, 1'b1, 8'hA5};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h3C};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h3C};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h3C};

        rst      = 1'b1;
        in_valid = 1'b1;
        src      = 8'hFF;
        #1;

        // Reset with live input, then the 2-lane-latency multi-lane table.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].s);
            check("tbl.u2.out_valid", {7'd0, ov2}, {7'd0, tbl[i].eov});
            check("tbl.u2.dst", d2, tbl[i].ed);
            if (i < 2) begin
                check("rst.u4.out_valid", {7'd0, ov4}, 8'h00);
                check("rst.u4.dst", d4, 8'h00);
            end
        end

        // Streaming on the single-lane, latency-1 counter.
        seq = 20'b1011_0000_1101_1001_1001;
        idle(4);
        for (int i = 19; i >= 0; i--) begin
            step(1'b0, 1'b1, {7'd0, seq[i]});
            check("stream.u1.out_valid", {7'd0, ov1}, 8'h01);
            check("stream.u1.dst", {7'd0, d1}, {7'd0, seq[i]});
        end

        // Valid gap on the latency-3 counter.
        idle(4);
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        check("gap.u3.out_valid0", {7'd0, ov3}, 8'h01);
        check("gap.u3.dst0", d3, 8'h01);
        idle(1);
        check("gap.u3.out_valid1", {7'd0, ov3}, 8'h00);
        check("gap.u3.dst1", d3, 8'h01);
        idle(1);
        check("gap.u3.out_valid2", {7'd0, ov3}, 8'h01);
        check("gap.u3.dst2", d3, 8'h00);

        // Mid-stream reset with three samples in flight, latency 4.
        idle(4);
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b1, 8'h33);
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("flush.u4.out_valid", {7'd0, ov4}, 8'h00);
            check("flush.u4.dst", d4, 8'h00);
        end
        step(1'b0, 1'b1, 8'h44);
        for (int i = 0; i < 3; i++) begin
            check("refill.u4.out_valid", {7'd0, ov4}, 8'h00);
            idle(1);
        end
        check("refill.u4.out_valid", {7'd0, ov4}, 8'h01);
        check("refill.u4.dst", d4, 8'h44);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(31) == 0), ($urandom_range(3) != 0),
                 8'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
